// File: rtl/fetch_pkg.sv
// Shared types, widths and commit_info layout for the fetch stage.
package fetch_pkg;

    localparam logic [63:0] RESET_PC = 64'h8000_0000;
    localparam int          COMMIT_W = 161;
    localparam int          INSTR_W  = 32;
    localparam int          XLEN     = 64;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Bit positions inside commit_info {commit, instr, pre_pc, pc}
    localparam int COMMIT_BIT = 160;
    localparam int INSTR_HI   = 159;
    localparam int PRE_PC_HI  = 127;
    localparam int PC_HI      = 63;

    typedef struct packed {
        logic [INSTR_W-1:0]  instr;
        logic [XLEN-1:0]     pre_pc;
        logic [XLEN-1:0]     pc;
        logic [COMMIT_W-1:0] commit;
    } fd_payload_t;

    localparam int PAYLOAD_W = $bits(fd_payload_t);

    function automatic logic misaligned(input logic [XLEN-1:0] target);
        return target[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side, execute-side and decode-side signals of the fetch controller.
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0]     pc_o;
    logic [INSTR_W-1:0]  fetch_i_instr;
    logic [XLEN-1:0]     fetch_i_pre_pc;
    logic [XLEN-1:0]     fetch_i_pc;
    logic [COMMIT_W-1:0] fetch_i_commit;
    logic                redirect_valid_i;
    logic [XLEN-1:0]     redirect_pc_i;
    logic                halt_i;
    logic                fd_valid_o;
    logic                fd_ready_i;
    logic [INSTR_W-1:0]  fd_instr_o;
    logic [XLEN-1:0]     fd_pc_o;
    logic [XLEN-1:0]     fd_pre_pc_o;
    logic [COMMIT_W-1:0] fd_commit_o;
    logic [XLEN-1:0]     fetch_cnt_o;
    logic                err_o;
    logic [1:0]          state_o;

    modport master (
        output pc_o, fd_valid_o, fd_instr_o, fd_pc_o, fd_pre_pc_o, fd_commit_o,
               fetch_cnt_o, err_o, state_o,
        input  fetch_i_instr, fetch_i_pre_pc, fetch_i_pc, fetch_i_commit,
               redirect_valid_i, redirect_pc_i, halt_i, fd_ready_i
    );

    modport slave (
        input  pc_o, fd_valid_o, fd_instr_o, fd_pc_o, fd_pre_pc_o, fd_commit_o,
               fetch_cnt_o, err_o, state_o,
        output fetch_i_instr, fetch_i_pre_pc, fetch_i_pc, fetch_i_commit,
               redirect_valid_i, redirect_pc_i, halt_i, fd_ready_i
    );

endinterface

// File: rtl/fetch_fd_slice.sv
// Valid/ready holding register between fetch and decode with load and flush.
module fetch_fd_slice
    import fetch_pkg::*;
#(
    parameter int DATA_W = PAYLOAD_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              flush,
    input  logic              ready,
    input  logic [DATA_W-1:0] din,
    output logic              valid,
    output logic [DATA_W-1:0] dout
);

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;

    // Stage p1: flush beats load; an unloaded entry leaves once decode takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
        end else begin
            if (flush)
                vld_p1 <= 1'b0;
            else if (load)
                vld_p1 <= 1'b1;
            else if (ready)
                vld_p1 <= 1'b0;
            if (load && !flush)
                data_p1 <= din;
        end
    end

    assign valid = vld_p1;
    assign dout  = data_p1;

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer for the fetch stage: owns the BOOT/RUN/HALT FSM, the PC,
// the handshake counter and the sticky misalignment error.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int          COMMIT_W = fetch_pkg::COMMIT_W
) (
    input logic     clk,
    input logic     rst_n,
    fetch_if.master bus
);

    localparam logic [1:0] ST_BOOT = 2'(BOOT);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_HALT = 2'(HALT);

    logic [1:0]          state_p0;
    logic [1:0]          state_nxt;
    logic [XLEN-1:0]     pc_p0;
    logic [XLEN-1:0]     cnt_p0;
    logic                err_p0;
    logic                vld_p1;
    logic                in_run;
    logic                take_halt;
    logic                take_redir;
    logic                bad_target;
    logic                advance;
    logic                handshake;
    logic [COMMIT_W-1:0] commit_in;
    fd_payload_t         payload_in;
    fd_payload_t         payload_out;

    // Priority in RUN is halt, then redirect, then advance
    always_comb begin
        in_run     = (state_p0 == ST_RUN);
        take_halt  = in_run && bus.halt_i;
        take_redir = in_run && !bus.halt_i && bus.redirect_valid_i;
        bad_target = take_redir && misaligned(bus.redirect_pc_i);
        advance    = in_run && !bus.halt_i && !bus.redirect_valid_i &&
                     (!vld_p1 || bus.fd_ready_i);
        handshake  = vld_p1 && bus.fd_ready_i;
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            ST_BOOT: state_nxt = ST_RUN;
            ST_RUN:  state_nxt = (take_halt || bad_target) ? ST_HALT : ST_RUN;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_HALT;
        endcase
    end

    assign commit_in  = bus.fetch_i_commit;
    assign payload_in = '{instr:  bus.fetch_i_instr,
                          pre_pc: bus.fetch_i_pre_pc,
                          pc:     bus.fetch_i_pc,
                          commit: commit_in};

    fetch_fd_slice #(
        .DATA_W(PAYLOAD_W)
    ) u_fd_slice (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (advance),
        .flush (take_redir),
        .ready (bus.fd_ready_i),
        .din   (payload_in),
        .valid (vld_p1),
        .dout  (payload_out)
    );

    // Stage p0: control state; a squashed handshake is not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= ST_BOOT;
            pc_p0    <= RESET_PC;
            cnt_p0   <= '0;
            err_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            if (take_redir && !bad_target)
                pc_p0 <= bus.redirect_pc_i;
            else if (advance)
                pc_p0 <= bus.fetch_i_pre_pc;
            if (handshake && !take_redir)
                cnt_p0 <= cnt_p0 + 64'd1;
            if (bad_target)
                err_p0 <= 1'b1;
        end
    end

    assign bus.pc_o        = pc_p0;
    assign bus.fd_valid_o  = vld_p1;
    assign bus.fd_instr_o  = payload_out.instr;
    assign bus.fd_pre_pc_o = payload_out.pre_pc;
    assign bus.fd_pc_o     = payload_out.pc;
    assign bus.fd_commit_o = payload_out.commit;
    assign bus.fetch_cnt_o = cnt_p0;
    assign bus.err_o       = err_p0;
    assign bus.state_o     = state_p0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a queue-based reference model predicts
// per-edge status and every decode handshake; two monitors pop and compare.
module tb_fetch_ctrl;

    typedef struct {
        logic [31:0]  instr;
        logic [63:0]  pre_pc;
        logic [63:0]  pc;
        logic [160:0] commit;
    } pay_t;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] cnt;
        logic        err;
        logic [1:0]  st;
        logic        vld;
        logic [63:0] fd_pc;
        logic [31:0] fd_instr;
    } stat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;

    pay_t  hold_q[$];
    pay_t  exp_q[$];
    stat_t st_q[$];

    int          m_state;
    logic [63:0] m_pc;
    logic [63:0] m_cnt;
    logic        m_err;

    fetch_if bus ();

    fetch_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic pay_t fmodel(input logic [63:0] pc);
        pay_t p;
        p.pc     = pc;
        p.instr  = pc[31:0] ^ {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
        p.pre_pc = (pc[5:2] == 4'hF) ? pc + 64'h40 : pc + 64'd4;
        p.commit = {1'b1, p.instr, p.pre_pc, p.pc};
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_w(input string nm, input logic [160:0] act, input logic [160:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge, from the inputs about to be sampled
    task automatic model_step(input logic rdy, input logic rv, input logic [63:0] rpc,
                              input logic hlt);
        bit    has;
        bit    squash;
        stat_t s;
        pay_t  p;
        has    = hold_q.size() > 0;
        squash = (m_state == 1) && !hlt && rv;
        if (has && rdy) exp_q.push_back(hold_q[0]);
        if (has && rdy && !squash) m_cnt = m_cnt + 64'd1;
        case (m_state)
            0: m_state = 1;
            1: begin
                if (hlt) begin
                    m_state = 2;
                    if (has && rdy) void'(hold_q.pop_front());
                end else if (rv) begin
                    hold_q.delete();
                    if (rpc[1:0] != 2'b00) begin
                        m_err   = 1'b1;
                        m_state = 2;
                    end else begin
                        m_pc = rpc;
                    end
                end else if (!has || rdy) begin
                    p = fmodel(m_pc);
                    hold_q.delete();
                    hold_q.push_back(p);
                    m_pc = p.pre_pc;
                end
            end
            default: if (has && rdy) void'(hold_q.pop_front());
        endcase
        s.pc  = m_pc;
        s.cnt = m_cnt;
        s.err = m_err;
        s.st  = 2'(m_state);
        s.vld = hold_q.size() > 0;
        s.fd_pc    = s.vld ? hold_q[0].pc : 64'd0;
        s.fd_instr = s.vld ? hold_q[0].instr : 32'd0;
        st_q.push_back(s);
    endtask

    // Drive inputs for the coming edge, model it, then wait until just after it
    task automatic cycle(input logic rdy, input logic rv = 1'b0,
                         input logic [63:0] rpc = 64'd0, input logic hlt = 1'b0);
        pay_t f;
        f = fmodel(bus.pc_o);
        bus.fd_ready_i       = rdy;
        bus.redirect_valid_i = rv;
        bus.redirect_pc_i    = rpc;
        bus.halt_i           = hlt;
        bus.fetch_i_instr    = f.instr;
        bus.fetch_i_pre_pc   = f.pre_pc;
        bus.fetch_i_pc       = f.pc;
        bus.fetch_i_commit   = f.commit;
        model_step(rdy, rv, rpc, hlt);
        @(posedge clk);
        #2;
    endtask

    // Asynchronous reset: outputs are checked before any clock edge occurs
    task automatic do_reset();
        rst_n = 1'b0;
        hold_q.delete();
        exp_q.delete();
        st_q.delete();
        m_state = 0;
        m_pc    = 64'h8000_0000;
        m_cnt   = 64'd0;
        m_err   = 1'b0;
        bus.fd_ready_i       = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.halt_i           = 1'b0;
        #1;
        chk("rst_pc", bus.pc_o, 64'h8000_0000);
        chk("rst_state", 64'(bus.state_o), 64'd0);
        chk("rst_valid", 64'(bus.fd_valid_o), 64'd0);
        chk("rst_fd_pc", bus.fd_pc_o, 64'd0);
        chk("rst_fd_instr", 64'(bus.fd_instr_o), 64'd0);
        chk("rst_cnt", bus.fetch_cnt_o, 64'd0);
        chk("rst_err", 64'(bus.err_o), 64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        stat_t s;
        #1;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("pc", bus.pc_o, s.pc);
            chk("cnt", bus.fetch_cnt_o, s.cnt);
            chk("err", 64'(bus.err_o), 64'(s.err));
            chk("state", 64'(bus.state_o), 64'(s.st));
            chk("fd_valid", 64'(bus.fd_valid_o), 64'(s.vld));
            if (s.vld) begin
                chk("fd_pc_held", bus.fd_pc_o, s.fd_pc);
                chk("fd_instr_held", 64'(bus.fd_instr_o), 64'(s.fd_instr));
            end
        end
    end

    always @(negedge clk) begin
        pay_t e;
        if (rst_n === 1'b1 && bus.fd_valid_o === 1'b1 && bus.fd_ready_i === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_run++;
                n_fail++;
                $display("FAIL hs_unexpected: got handshake pc %0h expected none", bus.fd_pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("hs_pc", bus.fd_pc_o, e.pc);
                chk("hs_pre_pc", bus.fd_pre_pc_o, e.pre_pc);
                chk("hs_instr", 64'(bus.fd_instr_o), 64'(e.instr));
                chk_w("hs_commit", bus.fd_commit_o, e.commit);
            end
        end
    end

    function automatic logic [63:0] rand_target(input bit allow_bad);
        logic [63:0] t;
        t = {32'd0, 16'h8000, 16'($urandom_range(0, 16'hFFFF))};
        t[1:0] = (allow_bad && ($urandom_range(0, 3) == 0)) ? 2'($urandom_range(1, 3)) : 2'b00;
        return t;
    endfunction

    initial begin
        rst_n = 1'b1;
        #1;
        do_reset();

        // Straight-line fetch at full throughput
        repeat (12) cycle(1'b1);
        // Three-cycle stall, then resume
        repeat (3) cycle(1'b0);
        repeat (5) cycle(1'b1);
        // Redirect while stalled
        cycle(1'b0);
        cycle(1'b0, 1'b1, 64'h8000_1000);
        repeat (3) cycle(1'b1);
        // Random ready and aligned redirects
        repeat (400) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                           rand_target(1'b0));
        // Halt with a held instruction under backpressure
        cycle(1'b1);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        cycle(1'b0);
        cycle(1'b0);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1, 1'b1, 64'h8000_2000);
        cycle(1'b0, 1'b0, 64'd0, 1'b1);
        cycle(1'b1);

        // Redirect and halt together
        do_reset();
        repeat (5) cycle(1'b1);
        cycle(1'b0);
        cycle(1'b0, 1'b1, 64'h8000_3000, 1'b1);
        repeat (3) cycle(1'b1);

        // Misaligned redirect, then ignored redirects
        do_reset();
        repeat (5) cycle(1'b1);
        cycle(1'b1, 1'b1, 64'h8000_1002);
        cycle(1'b1, 1'b1, 64'h8000_4000);
        cycle(1'b1, 1'b0, 64'd0, 1'b1);
        repeat (2) cycle(1'b1);

        // Asynchronous reset in the middle of a stall
        do_reset();
        repeat (6) cycle(1'b1);
        repeat (2) cycle(1'b0);
        #1;
        do_reset();

        // Randomised runs ending in halt or error
        for (int r = 0; r < 3; r++) begin
            do_reset();
            repeat (150) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                               rand_target(1'b1), $urandom_range(0, 63) == 0);
        end
        repeat (2) cycle(1'b1);

        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
